// File: rtl/regfile_scoreboard.sv
// Integer register file with a per-register dirty/tag scoreboard.
// N read ports, M write-back ports, one allocate (rename) port, global flush
// and a registered dirty-register counter. Register 0 is hardwired to zero.
// Optional same-cycle write-to-read bypass is enabled by defining RF_BYPASS_EN.
module regfile_scoreboard #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned NUM_REGS  = 32,
    parameter int unsigned AW        = $clog2(NUM_REGS),
    parameter int unsigned TAG_WIDTH = 2,
    parameter int unsigned NUM_RD    = 2,
    parameter int unsigned NUM_WR    = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        alloc_en,
    input  logic [AW-1:0]               alloc_addr,
    output logic [TAG_WIDTH-1:0]        alloc_tag,
    input  logic                        flush,
    input  logic [NUM_RD-1:0]           rd_en,
    input  logic [NUM_RD*AW-1:0]        rd_addr,
    output logic [NUM_RD*XLEN-1:0]      rd_data,
    output logic [NUM_RD-1:0]           rd_dirty,
    output logic [NUM_RD*TAG_WIDTH-1:0] rd_tag,
    input  logic [NUM_WR-1:0]           wr_en,
    input  logic [NUM_WR*AW-1:0]        wr_addr,
    input  logic [NUM_WR*TAG_WIDTH-1:0] wr_tag,
    input  logic [NUM_WR*XLEN-1:0]      wr_data,
    output logic [AW:0]                 dirty_cnt,
    output logic                        sb_idle
);

    logic [XLEN-1:0]      data_q [NUM_REGS];
    logic [XLEN-1:0]      data_d [NUM_REGS];
    logic [TAG_WIDTH-1:0] tag_q  [NUM_REGS];
    logic [TAG_WIDTH-1:0] tag_d  [NUM_REGS];
    logic [NUM_REGS-1:0]  dirty_q, dirty_d;
    logic [NUM_REGS-1:0]  wr_clean;
    logic [AW:0]          cnt_q, cnt_d;
    logic [AW-1:0]        wa;

    // Next-state: data writes (highest port wins), tag bump, dirty priority, popcount.
    always_comb begin
        data_d   = data_q;
        tag_d    = tag_q;
        dirty_d  = dirty_q;
        wr_clean = '0;
        wa       = '0;
        for (int j = 0; j < int'(NUM_WR); j++) begin
            wa = wr_addr[j*AW +: AW];
            if (wr_en[j] && wa != '0) begin
                data_d[wa] = wr_data[j*XLEN +: XLEN];
                // A write only retires the pending result it was tagged for.
                if (wr_tag[j*TAG_WIDTH +: TAG_WIDTH] == tag_q[wa]) begin
                    wr_clean[wa] = 1'b1;
                end
            end
        end
        for (int n = 0; n < int'(NUM_REGS); n++) begin
            if (wr_clean[n]) begin
                dirty_d[n] = 1'b0;
            end
        end
        // Allocation overrides a same-cycle write-back: that write is stale.
        if (alloc_en && alloc_addr != '0) begin
            dirty_d[alloc_addr] = 1'b1;
            tag_d[alloc_addr]   = tag_q[alloc_addr] + 1'b1;
        end
        if (flush) begin
            dirty_d = '0;
        end
        dirty_d[0] = 1'b0;
        cnt_d      = '0;
        for (int n = 0; n < int'(NUM_REGS); n++) begin
            cnt_d = cnt_d + {{AW{1'b0}}, dirty_d[n]};
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int n = 0; n < int'(NUM_REGS); n++) begin
                data_q[n] <= '0;
                tag_q[n]  <= '0;
            end
            dirty_q <= '0;
            cnt_q   <= '0;
        end else begin
            data_q  <= data_d;
            tag_q   <= tag_d;
            dirty_q <= dirty_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dirty_cnt = cnt_q;
    assign sb_idle   = (cnt_q == '0);
    assign alloc_tag = (alloc_addr == '0) ? '0 : tag_q[alloc_addr] + 1'b1;

    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rdat;
    logic            rdirty;

    // Read ports: data/dirty gated by rd_en, tag always visible.
    always_comb begin
        rd_data  = '0;
        rd_dirty = '0;
        rd_tag   = '0;
        ra       = '0;
        rdat     = '0;
        rdirty   = 1'b0;
        for (int k = 0; k < int'(NUM_RD); k++) begin
            ra     = rd_addr[k*AW +: AW];
            rdat   = data_q[ra];
            rdirty = dirty_q[ra];
`ifdef RF_BYPASS_EN
            for (int j = 0; j < int'(NUM_WR); j++) begin
                if (wr_en[j] && wr_addr[j*AW +: AW] != '0 && wr_addr[j*AW +: AW] == ra) begin
                    rdat   = wr_data[j*XLEN +: XLEN];
                    rdirty = dirty_q[ra];
                    if (wr_tag[j*TAG_WIDTH +: TAG_WIDTH] == tag_q[ra] &&
                        !(alloc_en && alloc_addr == ra)) begin
                        rdirty = 1'b0;
                    end
                end
            end
`endif
            rd_data[k*XLEN +: XLEN]           = rd_en[k] ? rdat : '0;
            rd_dirty[k]                       = rd_en[k] & rdirty;
            rd_tag[k*TAG_WIDTH +: TAG_WIDTH]  = tag_q[ra];
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed vector table followed by
// randomized traffic checked against a rule-level reference model.
module tb_regfile_scoreboard;

`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        alloc_en;
    logic [4:0]  alloc_addr;
    logic [1:0]  alloc_tag;
    logic        flush;
    logic [1:0]  rd_en;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_dirty;
    logic [3:0]  rd_tag;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [3:0]  wr_tag;
    logic [63:0] wr_data;
    logic [5:0]  dirty_cnt;
    logic        sb_idle;

    regfile_scoreboard dut (
        .clk        (clk),
        .reset      (reset),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .alloc_tag  (alloc_tag),
        .flush      (flush),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_dirty   (rd_dirty),
        .rd_tag     (rd_tag),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_tag     (wr_tag),
        .wr_data    (wr_data),
        .dirty_cnt  (dirty_cnt),
        .sb_idle    (sb_idle)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ae;
        logic [4:0]  aa;
        logic        fl;
        logic [1:0]  re;
        logic [4:0]  ra0, ra1;
        logic [1:0]  we;
        logic [4:0]  wa0, wa1;
        logic [1:0]  wt0, wt1;
        logic [31:0] wd0, wd1;
        logic [1:0]  at;
        logic [31:0] d0;
        logic        dy0;
        logic [1:0]  t0;
        logic [31:0] d1;
        logic        dy1;
        logic [1:0]  t1;
        logic [5:0]  cnt;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_fail = 0;

    // Reference model state
    logic [31:0] m_data [32];
    logic        m_dirty[32];
    logic [1:0]  m_tag  [32];
    logic        m_clr  [32];
    logic [4:0]  ra[2], wa[2];
    logic [1:0]  wt[2];
    logic [31:0] wd[2];
    logic [31:0] e_data;
    logic        e_dirty;
    logic [5:0]  e_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        alloc_en = 1'b0; alloc_addr = '0; flush = 1'b0;
        rd_en = '0; rd_addr = '0;
        wr_en = '0; wr_addr = '0; wr_tag = '0; wr_data = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        // ---------------- reset state ----------------
        #1 reset = 1'b1;
        rd_en = 2'b11;
        rd_addr = {5'd7, 5'd3};
        #1;
        chk("rst_data", rd_data[31:0], 32'h0);
        chk("rst_dirty", 32'(rd_dirty), 32'h0);
        chk("rst_cnt", 32'(dirty_cnt), 32'h0);
        chk("rst_idle", 32'(sb_idle), 32'h1);
        #1 reset = 1'b0;
        for (int r = 1; r < 32; r++) begin
            rd_addr = {5'(r), 5'(r)};
            #1;
            chk("init_data0", rd_data[31:0], 32'h0);
            chk("init_data1", rd_data[63:32], 32'h0);
            chk("init_dirty", 32'(rd_dirty), 32'h0);
            chk("init_tag", 32'(rd_tag), 32'h0);
        end
        chk("init_cnt", 32'(dirty_cnt), 32'h0);
        chk("init_idle", 32'(sb_idle), 32'h1);

        // ---------------- directed table ----------------
        // ae aa fl re ra0 ra1 | we wa0 wa1 wt0 wt1 wd0 wd1 | at d0 dy0 t0 d1 dy1 t1 cnt
        tbl.push_back(vec_t'{1,5,0,2'b11,5,0, 0,0,0,0,0,0,0, 1, 0,0,0, 0,0,0, 0});
        tbl.push_back(vec_t'{0,0,0,2'b01,5,5, 0,0,0,0,0,0,0, 0, 0,1,1, 0,0,1, 1});
        tbl.push_back(vec_t'{0,0,0,2'b11,5,0, 2'b01,5,0,1,0,32'hDEADBEEF,0,
                             0, BYP ? 32'hDEADBEEF : 32'h0, BYP ? 0 : 1, 1, 0,0,0, 1});
        tbl.push_back(vec_t'{0,0,0,2'b11,5,5, 0,0,0,0,0,0,0,
                             0, 32'hDEADBEEF,0,1, 32'hDEADBEEF,0,1, 0});
        tbl.push_back(vec_t'{1,7,0,2'b11,7,0, 0,0,0,0,0,0,0, 1, 0,0,0, 0,0,0, 0});
        tbl.push_back(vec_t'{1,7,0,2'b11,7,0, 0,0,0,0,0,0,0, 2, 0,1,1, 0,0,0, 1});
        tbl.push_back(vec_t'{0,0,0,2'b11,7,5, 2'b10,0,7,0,1,0,32'h11,
                             0, BYP ? 32'h11 : 32'h0,1,2, 32'hDEADBEEF,0,1, 1});
        tbl.push_back(vec_t'{0,0,0,2'b11,7,0, 2'b01,7,0,2,0,32'h22,0,
                             0, BYP ? 32'h22 : 32'h11, BYP ? 0 : 1, 2, 0,0,0, 1});
        tbl.push_back(vec_t'{0,0,0,2'b11,7,0, 0,0,0,0,0,0,0, 0, 32'h22,0,2, 0,0,0, 0});
        tbl.push_back(vec_t'{1,3,0,2'b11,3,0, 0,0,0,0,0,0,0, 1, 0,0,0, 0,0,0, 0});
        tbl.push_back(vec_t'{1,3,0,2'b11,3,0, 0,0,0,0,0,0,0, 2, 0,1,1, 0,0,0, 1});
        tbl.push_back(vec_t'{1,3,0,2'b11,3,0, 0,0,0,0,0,0,0, 3, 0,1,2, 0,0,0, 1});
        tbl.push_back(vec_t'{1,3,0,2'b11,3,0, 0,0,0,0,0,0,0, 0, 0,1,3, 0,0,0, 1});
        tbl.push_back(vec_t'{1,3,0,2'b11,3,0, 2'b01,3,0,0,0,32'h33,0,
                             1, BYP ? 32'h33 : 32'h0,1,0, 0,0,0, 1});
        tbl.push_back(vec_t'{0,0,0,2'b11,3,0, 0,0,0,0,0,0,0, 0, 32'h33,1,1, 0,0,0, 1});
        tbl.push_back(vec_t'{1,1,0,2'b11,1,0, 0,0,0,0,0,0,0, 1, 0,0,0, 0,0,0, 1});
        tbl.push_back(vec_t'{1,2,0,2'b11,1,0, 0,0,0,0,0,0,0, 1, 0,1,1, 0,0,0, 2});
        tbl.push_back(vec_t'{1,4,0,2'b11,2,0, 0,0,0,0,0,0,0, 1, 0,1,1, 0,0,0, 3});
        tbl.push_back(vec_t'{0,0,0,2'b11,4,3, 0,0,0,0,0,0,0, 0, 0,1,1, 32'h33,1,1, 4});
        tbl.push_back(vec_t'{0,0,0,2'b10,4,3, 0,0,0,0,0,0,0, 0, 0,0,1, 32'h33,1,1, 4});
        tbl.push_back(vec_t'{1,6,1,2'b11,6,0, 0,0,0,0,0,0,0, 1, 0,0,0, 0,0,0, 4});
        tbl.push_back(vec_t'{0,0,0,2'b11,6,3, 0,0,0,0,0,0,0, 0, 0,0,1, 32'h33,0,1, 0});
        tbl.push_back(vec_t'{0,0,0,2'b11,9,9, 2'b11,9,9,0,0,32'hA,32'hB,
                             0, BYP ? 32'hB : 32'h0,0,0, BYP ? 32'hB : 32'h0,0,0, 0});
        tbl.push_back(vec_t'{0,0,0,2'b11,9,9, 0,0,0,0,0,0,0, 0, 32'hB,0,0, 32'hB,0,0, 0});
        tbl.push_back(vec_t'{1,0,0,2'b11,0,0, 2'b01,0,0,0,0,32'h5,0, 0, 0,0,0, 0,0,0, 0});
        tbl.push_back(vec_t'{0,0,0,2'b11,0,0, 0,0,0,0,0,0,0, 0, 0,0,0, 0,0,0, 0});

        foreach (tbl[i]) begin
            @(posedge clk);
            #1;
            alloc_en = tbl[i].ae; alloc_addr = tbl[i].aa; flush = tbl[i].fl;
            rd_en = tbl[i].re; rd_addr = {tbl[i].ra1, tbl[i].ra0};
            wr_en = tbl[i].we; wr_addr = {tbl[i].wa1, tbl[i].wa0};
            wr_tag = {tbl[i].wt1, tbl[i].wt0}; wr_data = {tbl[i].wd1, tbl[i].wd0};
            #3;
            chk($sformatf("v%0d_alloc_tag", i), 32'(alloc_tag), 32'(tbl[i].at));
            chk($sformatf("v%0d_data0", i), rd_data[31:0], tbl[i].d0);
            chk($sformatf("v%0d_dirty0", i), 32'(rd_dirty[0]), 32'(tbl[i].dy0));
            chk($sformatf("v%0d_tag0", i), 32'(rd_tag[1:0]), 32'(tbl[i].t0));
            chk($sformatf("v%0d_data1", i), rd_data[63:32], tbl[i].d1);
            chk($sformatf("v%0d_dirty1", i), 32'(rd_dirty[1]), 32'(tbl[i].dy1));
            chk($sformatf("v%0d_tag1", i), 32'(rd_tag[3:2]), 32'(tbl[i].t1));
            chk($sformatf("v%0d_cnt", i), 32'(dirty_cnt), 32'(tbl[i].cnt));
            chk($sformatf("v%0d_idle", i), 32'(sb_idle), 32'(tbl[i].cnt == 6'd0));
        end

        // ---------------- randomized run vs. reference model ----------------
        @(posedge clk);
        #1 idle_inputs();
        reset = 1'b1;
        #2 reset = 1'b0;
        for (int n = 0; n < 32; n++) begin
            m_data[n] = '0; m_dirty[n] = 1'b0; m_tag[n] = '0;
        end
        for (int c = 0; c < 400; c++) begin
            @(posedge clk);
            #1;
            alloc_en   = 1'($urandom_range(0, 1));
            alloc_addr = 5'($urandom_range(0, 7));
            flush      = ($urandom_range(0, 15) == 0);
            rd_en      = 2'($urandom_range(0, 3));
            wr_en      = 2'($urandom_range(0, 3));
            for (int j = 0; j < 2; j++) begin
                ra[j] = 5'($urandom_range(0, 7));
                wa[j] = 5'($urandom_range(0, 7));
                wt[j] = ($urandom_range(0, 1) == 1) ? m_tag[wa[j]] : 2'($urandom_range(0, 3));
                wd[j] = $urandom;
            end
            rd_addr = {ra[1], ra[0]};
            wr_addr = {wa[1], wa[0]};
            wr_tag  = {wt[1], wt[0]};
            wr_data = {wd[1], wd[0]};
            #3;
            chk("rnd_alloc_tag", 32'(alloc_tag),
                32'((alloc_addr == 5'd0) ? 2'd0 : 2'(m_tag[alloc_addr] + 2'd1)));
            for (int k = 0; k < 2; k++) begin
                e_data  = m_data[ra[k]];
                e_dirty = m_dirty[ra[k]];
                if (BYP) begin
                    for (int j = 0; j < 2; j++) begin
                        if (wr_en[j] && wa[j] != 5'd0 && wa[j] == ra[k]) begin
                            e_data  = wd[j];
                            e_dirty = (wt[j] == m_tag[ra[k]] &&
                                       !(alloc_en && alloc_addr == ra[k])) ? 1'b0
                                                                           : m_dirty[ra[k]];
                        end
                    end
                end
                if (!rd_en[k]) begin
                    e_data  = '0;
                    e_dirty = 1'b0;
                end
                chk($sformatf("rnd%0d_data%0d", c, k), rd_data[k*32 +: 32], e_data);
                chk($sformatf("rnd%0d_dirty%0d", c, k), 32'(rd_dirty[k]), 32'(e_dirty));
                chk($sformatf("rnd%0d_tag%0d", c, k), 32'(rd_tag[k*2 +: 2]), 32'(m_tag[ra[k]]));
            end
            e_cnt = '0;
            for (int n = 0; n < 32; n++) e_cnt = e_cnt + 6'(m_dirty[n]);
            chk($sformatf("rnd%0d_cnt", c), 32'(dirty_cnt), 32'(e_cnt));
            chk($sformatf("rnd%0d_idle", c), 32'(sb_idle), 32'(e_cnt == 6'd0));

            // Advance the model by the rules for this cycle's inputs.
            for (int n = 0; n < 32; n++) m_clr[n] = 1'b0;
            for (int j = 0; j < 2; j++) begin
                if (wr_en[j] && wa[j] != 5'd0) begin
                    if (wt[j] == m_tag[wa[j]]) m_clr[wa[j]] = 1'b1;
                    m_data[wa[j]] = wd[j];
                end
            end
            for (int n = 1; n < 32; n++) begin
                if (flush) m_dirty[n] = 1'b0;
                else if (alloc_en && alloc_addr == 5'(n)) m_dirty[n] = 1'b1;
                else if (m_clr[n]) m_dirty[n] = 1'b0;
            end
            if (alloc_en && alloc_addr != 5'd0) m_tag[alloc_addr] = m_tag[alloc_addr] + 2'd1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
